// File: rtl/noc_output_arbiter.sv
// Packet-aware round-robin switch arbiter for one mesh router output port.
// A winning HEAD locks the output to its input until TAIL; grants are gated by per-VC downstream credits.
module noc_output_arbiter #(
    parameter int PORTS     = 5,
    parameter int VCS       = 4,
    parameter int BUF_DEPTH = 4,
    localparam int VC_SIZE  = $clog2(VCS),
    localparam int SEL_SIZE = $clog2(PORTS),
    localparam int CNT_SIZE = $clog2(BUF_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS-1:0]         req_i,
    input  logic [PORTS*2-1:0]       label_i,
    input  logic [PORTS*VC_SIZE-1:0] vc_i,
    input  logic                     credit_valid_i,
    input  logic [VC_SIZE-1:0]       credit_vc_i,
    output logic [PORTS-1:0]         grant_o,
    output logic [SEL_SIZE-1:0]      sel_o,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [VCS*CNT_SIZE-1:0]  credit_cnt_o
);
    typedef enum logic {IDLE, LOCKED} state_e;

    localparam logic [1:0] LBL_HEAD     = 2'd0;
    localparam logic [1:0] LBL_BODY     = 2'd1;
    localparam logic [1:0] LBL_TAIL     = 2'd2;
    localparam logic [1:0] LBL_HEADTAIL = 2'd3;

    state_e              state_q, state_d;
    logic [SEL_SIZE-1:0] owner_q, owner_d;
    logic [SEL_SIZE-1:0] rrPtr_q, rrPtr_d;
    logic [VC_SIZE-1:0]  lockVc_q, lockVc_d;
    logic [CNT_SIZE-1:0] credit_q [VCS];
    logic [CNT_SIZE-1:0] credit_d [VCS];
    logic                err_q, err_d;

    logic                winValid;
    logic [SEL_SIZE-1:0] winIdx;
    logic [1:0]          winLabel;
    logic [VC_SIZE-1:0]  winVc;
    logic                protoErr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rrPtr_q  <= '0;
            lockVc_q <= '0;
            err_q    <= 1'b0;
            for (int v = 0; v < VCS; v++) begin
                credit_q[v] <= CNT_SIZE'(BUF_DEPTH);
            end
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rrPtr_q  <= rrPtr_d;
            lockVc_q <= lockVc_d;
            err_q    <= err_d;
            for (int v = 0; v < VCS; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    always_comb begin
        logic inc;
        logic dec;
        state_d  = state_q;
        owner_d  = owner_q;
        rrPtr_d  = rrPtr_q;
        lockVc_d = lockVc_q;
        err_d    = err_q | protoErr;
        credit_d = credit_q;
        inc      = 1'b0;
        dec      = 1'b0;
        if (winValid) begin
            if (state_q == IDLE) begin
                rrPtr_d = (winIdx == SEL_SIZE'(PORTS - 1)) ? '0 : winIdx + 1'b1;
                if (winLabel == LBL_HEAD) begin
                    state_d  = LOCKED;
                    owner_d  = winIdx;
                    lockVc_d = winVc;
                end
            end else if (winLabel == LBL_TAIL) begin
                state_d = IDLE;
            end
        end
        // A grant and a returned credit on the same VC cancel, so neither can overflow.
        for (int v = 0; v < VCS; v++) begin
            dec = winValid && (winVc == VC_SIZE'(v));
            inc = credit_valid_i && (credit_vc_i == VC_SIZE'(v));
            if (inc && !dec) begin
                if (credit_q[v] == CNT_SIZE'(BUF_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + 1'b1;
                end
            end else if (dec && !inc) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end
        end
    end

    always_comb begin
        int                 idx;
        logic [1:0]         lbl;
        logic [VC_SIZE-1:0] vc;
        winValid = 1'b0;
        winIdx   = '0;
        winLabel = LBL_HEAD;
        winVc    = '0;
        protoErr = 1'b0;
        idx      = 0;
        lbl      = LBL_HEAD;
        vc       = '0;
        if (state_q == IDLE) begin
            for (int k = 0; k < PORTS; k++) begin
                idx = int'(rrPtr_q) + k;
                if (idx >= PORTS) begin
                    idx = idx - PORTS;
                end
                lbl = label_i[2*idx +: 2];
                vc  = vc_i[VC_SIZE*idx +: VC_SIZE];
                if (req_i[idx]) begin
                    if (lbl == LBL_BODY || lbl == LBL_TAIL) begin
                        protoErr = 1'b1;
                    end else if (!winValid && credit_q[vc] != '0) begin
                        winValid = 1'b1;
                        winIdx   = SEL_SIZE'(idx);
                        winLabel = lbl;
                        winVc    = vc;
                    end
                end
            end
        end else begin
            lbl   = label_i[2*owner_q +: 2];
            winVc = lockVc_q;
            if (req_i[owner_q]) begin
                if (lbl == LBL_HEAD || lbl == LBL_HEADTAIL) begin
                    protoErr = 1'b1;
                end else if (credit_q[lockVc_q] != '0) begin
                    winValid = 1'b1;
                    winIdx   = owner_q;
                    winLabel = lbl;
                end
            end
        end
        if (rst) begin
            winValid = 1'b0;
            protoErr = 1'b0;
        end
        grant_o = '0;
        sel_o   = '0;
        if (winValid) begin
            grant_o[winIdx] = 1'b1;
            sel_o           = winIdx;
        end
        for (int v = 0; v < VCS; v++) begin
            credit_cnt_o[CNT_SIZE*v +: CNT_SIZE] = credit_q[v];
        end
    end

    assign busy_o = (state_q == LOCKED);
    assign err_o  = err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: directed scenarios followed by randomized well-formed packet traffic,
// all checked each cycle against a behavioural model of the arbitration and credit rules.
module tb_noc_output_arbiter;
    localparam logic [1:0] L_HEAD = 2'd0;
    localparam logic [1:0] L_BODY = 2'd1;
    localparam logic [1:0] L_TAIL = 2'd2;
    localparam logic [1:0] L_HT   = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req_i;
    logic [9:0]  label_i;
    logic [9:0]  vc_i;
    logic        credit_valid_i;
    logic [1:0]  credit_vc_i;
    logic [4:0]  grant_o;
    logic [2:0]  sel_o;
    logic        busy_o;
    logic        err_o;
    logic [11:0] credit_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    bit         dRst;
    logic [4:0] dReq;
    logic [9:0] dLab;
    logic [9:0] dVc;
    bit         dCv;
    logic [1:0] dCvc;

    int mCredit [4];
    bit mLocked;
    int mOwner;
    int mLockVc;
    int mRr;
    bit mErr;

    logic [4:0] eGrant;
    logic [2:0] eSel;
    int         eWin;
    int         eVc;
    logic [1:0] eLabel;
    bit         eProto;

    int pLen [5];
    int pPos [5];
    int pVc  [5];

    noc_output_arbiter #(.PORTS(5), .VCS(4), .BUF_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .label_i        (label_i),
        .vc_i           (vc_i),
        .credit_valid_i (credit_valid_i),
        .credit_vc_i    (credit_vc_i),
        .grant_o        (grant_o),
        .sel_o          (sel_o),
        .busy_o         (busy_o),
        .err_o          (err_o),
        .credit_cnt_o   (credit_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] lp(int p, logic [1:0] l);
        logic [9:0] r;
        r = '0;
        r[2*p +: 2] = l;
        return r;
    endfunction

    function automatic logic [1:0] labOf(int p);
        return dLab[2*p +: 2];
    endfunction

    function automatic int vcOf(int p);
        return int'(dVc[2*p +: 2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int v = 0; v < 4; v++) mCredit[v] = 4;
        mLocked = 0;
        mOwner  = 0;
        mLockVc = 0;
        mRr     = 0;
        mErr    = 0;
    endtask

    task automatic modelEval();
        int p;
        eGrant = '0;
        eSel   = '0;
        eWin   = -1;
        eVc    = 0;
        eLabel = L_HEAD;
        eProto = 0;
        if (dRst) return;
        if (!mLocked) begin
            for (int i = 0; i < 5; i++)
                if (dReq[i] && (labOf(i) == L_BODY || labOf(i) == L_TAIL)) eProto = 1;
            for (int k = 0; k < 5; k++) begin
                p = (mRr + k) % 5;
                if (eWin < 0 && dReq[p] && (labOf(p) == L_HEAD || labOf(p) == L_HT) && mCredit[vcOf(p)] > 0)
                    eWin = p;
            end
            if (eWin >= 0) eVc = vcOf(eWin);
        end else begin
            eVc = mLockVc;
            if (dReq[mOwner]) begin
                if (labOf(mOwner) == L_HEAD || labOf(mOwner) == L_HT) eProto = 1;
                else if (mCredit[mLockVc] > 0) eWin = mOwner;
            end
        end
        if (eWin >= 0) begin
            eGrant[eWin] = 1'b1;
            eSel   = 3'(eWin);
            eLabel = labOf(eWin);
        end
    endtask

    task automatic modelCommit();
        if (dRst) begin
            modelReset();
            return;
        end
        if (eProto) mErr = 1;
        if (eWin >= 0) begin
            mCredit[eVc] = mCredit[eVc] - 1;
            mRr = (eWin + 1) % 5;
            if (!mLocked && eLabel == L_HEAD) begin
                mLocked = 1;
                mOwner  = eWin;
                mLockVc = eVc;
            end else if (mLocked && eLabel == L_TAIL) begin
                mLocked = 0;
            end
        end
        if (dCv) begin
            if (mCredit[dCvc] == 4) mErr = 1;
            else mCredit[dCvc] = mCredit[dCvc] + 1;
        end
    endtask

    task automatic checkOutput();
        logic [11:0] expCred;
        for (int v = 0; v < 4; v++) expCred[3*v +: 3] = 3'(mCredit[v]);
        chk("grant", 32'(grant_o), 32'(eGrant));
        chk("sel", 32'(sel_o), 32'(eSel));
        chk("busy", 32'(busy_o), 32'(mLocked));
        chk("err", 32'(err_o), 32'(mErr));
        chk("credits", 32'(credit_cnt_o), 32'(expCred));
    endtask

    task automatic applyStimulus(input bit r, input logic [4:0] rq, input logic [9:0] lb,
                                 input logic [9:0] vcs, input bit cv, input logic [1:0] cvc);
        @(negedge clk);
        dRst = r; dReq = rq; dLab = lb; dVc = vcs; dCv = cv; dCvc = cvc;
        rst = r; req_i = rq; label_i = lb; vc_i = vcs; credit_valid_i = cv; credit_vc_i = cvc;
        #1;
        modelEval();
        checkOutput();
        modelCommit();
    endtask

    task automatic newPacket(input int p);
        pLen[p] = $urandom_range(1, 5);
        pPos[p] = 0;
        pVc[p]  = $urandom_range(0, 3);
    endtask

    initial begin
        int         rrExp [6];
        logic [4:0] rq;
        logic [9:0] lb;
        logic [9:0] vcs;
        bit         cv;
        logic [1:0] cvc;
        int         start;
        rrExp = '{1, 3, 4, 1, 3, 4};

        rst = 1'b1; req_i = '0; label_i = '0; vc_i = '0; credit_valid_i = 1'b0; credit_vc_i = '0;
        modelReset();
        @(posedge clk);

        $display("[TB] reset with requests active");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 5'b11111, '0, '0, 0, 0);
            chk("rst_grant", 32'(grant_o), 32'h0);
            chk("rst_sel", 32'(sel_o), 32'h0);
        end
        applyStimulus(0, '0, '0, '0, 0, 0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_credits", 32'(credit_cnt_o), 32'h924);

        $display("[TB] round robin");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 5'b11010, lp(1, L_HT) | lp(3, L_HT) | lp(4, L_HT), '0, 1, 0);
            chk($sformatf("rr_sel%0d", i), 32'(sel_o), 32'(rrExp[i]));
            chk($sformatf("rr_grant%0d", i), 32'(grant_o), 32'(1 << rrExp[i]));
        end

        $display("[TB] packet lock");
        applyStimulus(1, '0, '0, '0, 0, 0);
        applyStimulus(0, 5'b00100, lp(2, L_HEAD), lp(2, 2'd1), 0, 0);
        chk("lock_head", 32'(sel_o), 32'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 5'b00101, lp(2, (i == 2) ? L_TAIL : L_BODY) | lp(0, L_HEAD), lp(2, 2'd1), 0, 0);
            chk($sformatf("lock_grant%0d", i), 32'(grant_o), 32'h04);
            chk($sformatf("lock_busy%0d", i), 32'(busy_o), 32'h1);
        end
        applyStimulus(0, 5'b00001, lp(0, L_HEAD), '0, 0, 0);
        chk("lock_next", 32'(grant_o), 32'h01);
        chk("lock_released", 32'(busy_o), 32'h0);
        applyStimulus(0, 5'b00001, lp(0, L_TAIL), '0, 0, 0);
        chk("lock_next_tail", 32'(grant_o), 32'h01);

        $display("[TB] credit stall");
        applyStimulus(1, '0, '0, '0, 0, 0);
        for (int f = 0; f < 4; f++) begin
            applyStimulus(0, 5'b10000, lp(4, (f == 0) ? L_HEAD : L_BODY), lp(4, 2'd3), 0, 0);
            chk($sformatf("stall_flit%0d", f), 32'(grant_o), 32'h10);
        end
        applyStimulus(0, 5'b10000, lp(4, L_BODY), lp(4, 2'd3), 0, 0);
        chk("stall_nogrant", 32'(grant_o), 32'h0);
        chk("stall_busy", 32'(busy_o), 32'h1);
        chk("stall_vc3_zero", 32'(credit_cnt_o[11:9]), 32'h0);
        applyStimulus(0, 5'b10000, lp(4, L_BODY), lp(4, 2'd3), 1, 3);
        chk("stall_credit_cycle", 32'(grant_o), 32'h0);
        applyStimulus(0, 5'b10000, lp(4, L_BODY), lp(4, 2'd3), 1, 3);
        chk("stall_resume", 32'(grant_o), 32'h10);
        applyStimulus(0, 5'b10000, lp(4, L_TAIL), lp(4, 2'd3), 0, 0);
        chk("stall_tail", 32'(grant_o), 32'h10);
        applyStimulus(0, '0, '0, '0, 0, 0);
        chk("stall_idle", 32'(busy_o), 32'h0);

        $display("[TB] credit edge cases");
        applyStimulus(1, '0, '0, '0, 0, 0);
        applyStimulus(0, 5'b00010, lp(1, L_HT), lp(1, 2'd2), 1, 2);
        chk("edge_vc2_grant", 32'(grant_o), 32'h02);
        applyStimulus(0, '0, '0, '0, 1, 0);
        chk("edge_vc2_same", 32'(credit_cnt_o[8:6]), 32'd4);
        chk("edge_err_clear", 32'(err_o), 32'h0);
        applyStimulus(0, '0, '0, '0, 0, 0);
        chk("edge_vc0_sat", 32'(credit_cnt_o[2:0]), 32'd4);
        chk("edge_overflow_err", 32'(err_o), 32'h1);

        $display("[TB] protocol errors and reset mid-packet");
        applyStimulus(1, '0, '0, '0, 0, 0);
        applyStimulus(0, 5'b00001, lp(0, L_BODY), '0, 0, 0);
        chk("proto_body_idle", 32'(grant_o), 32'h0);
        applyStimulus(0, '0, '0, '0, 0, 0);
        chk("proto_err_idle", 32'(err_o), 32'h1);
        applyStimulus(1, '0, '0, '0, 0, 0);
        applyStimulus(0, 5'b01000, lp(3, L_HEAD), lp(3, 2'd1), 0, 0);
        chk("proto_head", 32'(grant_o), 32'h08);
        applyStimulus(0, 5'b01000, lp(3, L_HEAD), lp(3, 2'd1), 0, 0);
        chk("proto_owner_head", 32'(grant_o), 32'h0);
        applyStimulus(0, '0, '0, '0, 0, 0);
        chk("proto_err_locked", 32'(err_o), 32'h1);
        chk("proto_still_busy", 32'(busy_o), 32'h1);
        applyStimulus(1, 5'b01000, lp(3, L_BODY), lp(3, 2'd1), 0, 0);
        chk("midrst_grant", 32'(grant_o), 32'h0);
        applyStimulus(0, '0, '0, '0, 0, 0);
        chk("midrst_busy", 32'(busy_o), 32'h0);
        chk("midrst_err", 32'(err_o), 32'h0);
        chk("midrst_credits", 32'(credit_cnt_o), 32'h924);

        $display("[TB] randomized packet traffic");
        applyStimulus(1, '0, '0, '0, 0, 0);
        for (int p = 0; p < 5; p++) newPacket(p);
        for (int c = 0; c < 400; c++) begin
            rq = '0;
            lb = '0;
            vcs = 10'($urandom);
            for (int p = 0; p < 5; p++) begin
                rq[p] = ($urandom_range(0, 3) != 0);
                vcs[2*p +: 2] = 2'(pVc[p]);
                if (pLen[p] == 1) lb[2*p +: 2] = L_HT;
                else if (pPos[p] == 0) lb[2*p +: 2] = L_HEAD;
                else if (pPos[p] == pLen[p] - 1) lb[2*p +: 2] = L_TAIL;
                else lb[2*p +: 2] = L_BODY;
            end
            cv  = ($urandom_range(0, 1) == 1);
            cvc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) != 0) begin
                start = $urandom_range(0, 3);
                for (int k = 3; k >= 0; k--)
                    if (mCredit[(start + k) % 4] < 4) cvc = 2'((start + k) % 4);
            end
            applyStimulus(0, rq, lb, vcs, cv, cvc);
            if (eWin >= 0) begin
                pPos[eWin] = pPos[eWin] + 1;
                if (pPos[eWin] == pLen[eWin]) newPacket(eWin);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/noc_output_arbiter.md
# noc_output_arbiter

Packet-aware round-robin switch arbiter for one router output port in the 6x6 mesh NoC. It chooses which of the five input ports (LOCAL, NORTH, EAST, SOUTH, WEST) may send a flit through the crossbar to this output. Once a HEAD flit wins, it holds the grant for that input until the packet's TAIL passes. It tracks downstream buffer credits per virtual channel and only grants when the target VC has space. One instance sits beside each crossbar output in the router.

## Interface
Parameters:
- PORTS, in_Port_Cnt (5): number of requesting input ports.
- VCS, vc_Num (4): number of downstream virtual channels.
- BUF_DEPTH, 4: downstream flit slots per VC; this is the initial credit count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req_i  in  PORTS  input i has a flit at its buffer head routed to this output.
- label_i  in  PORTS*2  flit_Data_Label of each input's head flit (HEAD/BODY/TAIL/HEADTAIL).
- vc_i  in  PORTS*VC_Size  downstream VC id carried by each input's flit.
- credit_valid_i  in  1  downstream freed one slot.
- credit_vc_i  in  VC_Size  VC of the returned credit.
- grant_o  out  PORTS  one-hot grant; the input pops its flit in the same cycle.
- sel_o  out  in_port_Size  binary index of the granted input, for the crossbar mux; 0 when no grant.
- busy_o  out  1  arbiter is locked to a packet.
- err_o  out  1  sticky protocol or credit error flag.
- credit_cnt_o  out  VCS*3  per-VC credit counters, VC0 in the LSBs.

## Operation
- State: IDLE or LOCKED. LOCKED stores owner (in_port_Size bits) and lock_vc (VC_Size bits). Also a round-robin pointer rr_ptr (0..PORTS-1), per-VC credit counters of width $clog2(BUF_DEPTH+1), and err.
- Eligible input in IDLE: req_i[i] is set, label is HEAD or HEADTAIL, and credit[vc_i[i]] > 0.
- Eligible input in LOCKED: only the owner, with req_i[owner] set, label BODY or TAIL, and credit[lock_vc] > 0. vc_i is ignored while LOCKED.
- Winner selection (IDLE): the first eligible input found scanning upward from rr_ptr, wrapping PORTS-1 to 0.
- On any grant, rr_ptr becomes winner+1 mod PORTS. rr_ptr is unchanged in LOCKED.
- Transitions:
  - IDLE, HEAD granted -> LOCKED, capturing owner and lock_vc.
  - IDLE, HEADTAIL granted -> stays IDLE.
  - LOCKED, BODY granted -> stays LOCKED.
  - LOCKED, TAIL granted -> IDLE.
- Protocol errors set err (sticky until rst) and produce no grant:
  - In IDLE, an input requests with BODY or TAIL.
  - In LOCKED, the owner requests with HEAD or HEADTAIL.
- Requests from non-owners in LOCKED are neither an error nor granted.
- Credit update per VC:
  - Decrement by 1 on a grant to that VC.
  - Increment by 1 on credit_valid_i for that VC.
  - Both on the same VC in one cycle: count unchanged.
  - Increment when count is already BUF_DEPTH with no same-VC grant: count saturates at BUF_DEPTH and err is set.
- Grant decisions use the registered credit counts. A credit returned in cycle N becomes usable in cycle N+1.

## Timing
- grant_o and sel_o are combinational from registered state plus the current req_i, label_i and vc_i. They are forced to 0 while rst is high.
- State, rr_ptr, credit and err updates take effect at the next rising edge.
- Throughput: one flit per cycle when credits allow. An L-flit packet with continuous requests and enough credits is granted in L consecutive cycles.
- The next packet's HEAD can be granted in the cycle after TAIL, with no bubble beyond that.
- Reset values:
  - State IDLE; rr_ptr = 0; every credit counter = BUF_DEPTH (credit_cnt_o = 4 per VC).
  - err_o = 0, busy_o = 0, grant_o = 0, sel_o = 0.
- Reset mid-packet drops the lock and restores all credits. Upstream and downstream are reset together.

## Test plan
- Reset: hold rst for 2 cycles with requests active -> grant_o = 0, sel_o = 0, busy_o = 0, err_o = 0, credit_cnt_o = 4 on every VC.
- Round-robin: inputs 1, 3 and 4 send continuous HEADTAIL on VC0, with credits returned every cycle -> grants go 1, 3, 4, 1, 3, ... and sel_o matches.
- Packet lock: input 2 sends HEAD, BODY, BODY, TAIL on VC1 while input 0 holds a HEAD -> input 2 granted for 4 cycles with busy_o = 1, then input 0 granted in the next cycle.
- Credit stall: input 4 sends a 6-flit packet on VC3 with no credit return -> 4 grants, then a stall with busy_o = 1 and VC3 credit = 0. A credit returned in cycle k -> grant in cycle k+1.
- Credit edge cases:
  - Grant and credit return on VC2 in the same cycle -> VC2 count unchanged.
  - Credit return on VC0 while its count is 4 -> count stays 4 and err_o = 1.
- Protocol error and reset mid-packet:
  - Input 0 sends BODY while IDLE -> no grant, err_o = 1.
  - rst asserted in the middle of a LOCKED packet -> IDLE, credits back to 4, err_o = 0.
